// File: rtl/procb_thread_sched_if.sv
// Thread-address bundle between the process_bytes controller and its thread scheduler.
// Master drives the mask and advance strobes. The slave returns the current, look-ahead and procb thread numbers.
interface procb_thread_sched_if #(
  parameter int N_CC     = 8,
  parameter int THREAD_W = 4
);
  logic [N_CC-1:0]     cc_en;
  logic                set_next_core_ctx_num;
  logic                set_next_seq_num;
  logic                set_next_procb_rd_thread_num;
  logic [THREAD_W-1:0] core_thread_num;
  logic                core_thread_valid;
  logic [THREAD_W-1:0] next_thread_num;
  logic                next_valid;
  logic [THREAD_W-1:0] procb_rd_thread_num;
  logic [THREAD_W-1:0] procb_rd_thread_num2;
  logic                procb_rd_valid;

  modport master (
    output cc_en, set_next_core_ctx_num, set_next_seq_num, set_next_procb_rd_thread_num,
    input  core_thread_num, core_thread_valid, next_thread_num, next_valid,
    input  procb_rd_thread_num, procb_rd_thread_num2, procb_rd_valid
  );

  modport slave (
    input  cc_en, set_next_core_ctx_num, set_next_seq_num, set_next_procb_rd_thread_num,
    output core_thread_num, core_thread_valid, next_thread_num, next_valid,
    output procb_rd_thread_num, procb_rd_thread_num2, procb_rd_valid
  );
endinterface

// File: rtl/procb_thread_sched.sv
// Round-robin {context, sequence} thread generator for process_bytes; disabled contexts are skipped.
// Every strobe takes effect on the next edge. next_thread_num is the only combinational output. There is no backpressure.
module procb_thread_sched #(
  parameter int N_CORES = 4,
  parameter int N_CTX   = 2,
  parameter int N_SEQ   = 2
) (
  input logic CLK,
  input logic reset,
  procb_thread_sched_if.slave bus
);
  localparam int N_CC     = N_CORES * N_CTX;
  localparam int CC_W     = (N_CC > 1) ? $clog2(N_CC) : 1;
  localparam int SEQ_W    = (N_SEQ > 1) ? $clog2(N_SEQ) : 1;
  localparam int THREAD_W = CC_W + SEQ_W;

  typedef logic [CC_W-1:0]  cc_t;
  typedef logic [SEQ_W-1:0] seq_t;

  // Circular scan for the first enabled context, starting at base (incl) or base+1.
  function automatic logic [CC_W:0] find_en(input logic [N_CC-1:0] en, input cc_t base,
                                            input logic incl);
    logic found;
    cc_t  idx;
    cc_t  j;
    found = 1'b0;
    idx   = '0;
    for (int k = 0; k < N_CC; k++) begin
      j = cc_t'((int'(base) + (incl ? 0 : 1) + k) % N_CC);
      if (!found && en[j]) begin
        found = 1'b1;
        idx   = j;
      end
    end
    return {found, idx};
  endfunction

  cc_t                 cc_cur_q, cc_cur_d, cc_next_q, cc_next_d;
  logic                next_valid_q, next_valid_d;
  logic                core_thread_valid_q, core_thread_valid_d;
  logic                procb_rd_valid_q, procb_rd_valid_d;
  seq_t                seq_r_q, seq_r_d;
  seq_t                seq_q [N_CC];
  seq_t                seq_d [N_CC];
  logic [THREAD_W-1:0] procb_q, procb_d, procb2_q, procb2_d;
  seq_t                seq_cur_inc;
  logic                seq_adv;
  logic [CC_W:0]       search;

  always_comb begin
    seq_d               = seq_q;
    cc_cur_d            = cc_cur_q;
    core_thread_valid_d = core_thread_valid_q;
    seq_r_d             = seq_r_q;
    procb_d             = procb_q;
    procb2_d            = procb2_q;
    procb_rd_valid_d    = procb_rd_valid_q;

    seq_adv     = (N_SEQ > 1) && bus.set_next_seq_num && core_thread_valid_q;
    seq_cur_inc = (seq_q[cc_cur_q] == seq_t'(N_SEQ - 1)) ? '0 : seq_q[cc_cur_q] + seq_t'(1);
    if (seq_adv) seq_d[cc_cur_q] = seq_cur_inc;

    // Loads read seq_d so a same-cycle increment of the current context is not lost.
    if (bus.set_next_core_ctx_num) begin
      cc_cur_d            = next_valid_q ? cc_next_q : cc_cur_q;
      core_thread_valid_d = next_valid_q;
      seq_r_d             = seq_d[cc_next_q];
      search              = find_en(bus.cc_en, cc_next_q, 1'b0);
    end else begin
      search = find_en(bus.cc_en, cc_cur_q, !core_thread_valid_q);
    end
    {next_valid_d, cc_next_d} = search;

    if (bus.set_next_procb_rd_thread_num) begin
      procb_d          = {cc_next_q, seq_d[cc_next_q]};
      procb2_d         = {cc_next_q, seq_d[cc_next_q]};
      procb_rd_valid_d = next_valid_q;
    end
  end

  // procb2_q duplicates procb_q on purpose: each copy feeds a different far-away consumer.
  always_ff @(posedge CLK) begin
    if (reset) begin
      cc_cur_q            <= '0;
      cc_next_q           <= '0;
      next_valid_q        <= 1'b0;
      core_thread_valid_q <= 1'b0;
      seq_r_q             <= '0;
      procb_q             <= '0;
      procb2_q            <= '0;
      procb_rd_valid_q    <= 1'b0;
      for (int i = 0; i < N_CC; i++) seq_q[i] <= '0;
    end else begin
      cc_cur_q            <= cc_cur_d;
      cc_next_q           <= cc_next_d;
      next_valid_q        <= next_valid_d;
      core_thread_valid_q <= core_thread_valid_d;
      seq_r_q             <= seq_r_d;
      procb_q             <= procb_d;
      procb2_q            <= procb2_d;
      procb_rd_valid_q    <= procb_rd_valid_d;
      for (int i = 0; i < N_CC; i++) seq_q[i] <= seq_d[i];
    end
  end

  assign bus.core_thread_num      = {cc_cur_q, seq_r_q};
  assign bus.core_thread_valid    = core_thread_valid_q;
  assign bus.next_thread_num      = {cc_next_q, seq_q[cc_next_q]};
  assign bus.next_valid           = next_valid_q;
  assign bus.procb_rd_thread_num  = procb_q;
  assign bus.procb_rd_thread_num2 = procb2_q;
  assign bus.procb_rd_valid       = procb_rd_valid_q;
endmodule
